// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the PC sequencer: state codes, default widths
// and the next-PC source select.
package pc_sequencer_pkg;

  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_INSTR_W = 32;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_FETCH = 3'd1;
  localparam state_t ST_WAIT  = 3'd2;
  localparam state_t ST_EXEC  = 3'd3;
  localparam state_t ST_HALT  = 3'd4;

  typedef enum logic [1:0] {
    SEL_INC = 2'd0,
    SEL_BR  = 2'd1,
    SEL_JMP = 2'd2
  } pc_sel_e;

  // Jump outranks branch, branch outranks increment.
  function automatic pc_sel_e pc_select(input logic jump_en, input logic br_taken);
    if (jump_en)       return SEL_JMP;
    else if (br_taken) return SEL_BR;
    else               return SEL_INC;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch/execute bundle between the PC sequencer (master) and its
// instruction memory / execute stage environment (slave).
interface pc_sequencer_if
  import pc_sequencer_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W
) ();

  logic               start;
  logic               halt_req;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_data;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               exec_done;
  logic               jump_en;
  logic [ADDR_W-1:0]  jump_target;
  logic               br_taken;
  logic [ADDR_W-1:0]  br_offset;
  logic [ADDR_W-1:0]  pc;
  logic               busy;
  logic               fault;
  logic               halted;

  modport master (
    input  start, halt_req, imem_ack, imem_data,
           exec_done, jump_en, jump_target, br_taken, br_offset,
    output imem_req, imem_addr, instr, instr_valid, pc, busy, fault, halted
  );

  modport slave (
    output start, halt_req, imem_ack, imem_data,
           exec_done, jump_en, jump_target, br_taken, br_offset,
    input  imem_req, imem_addr, instr, instr_valid, pc, busy, fault, halted
  );

endinterface

// File: rtl/pc_next_calc.sv
// Combinational next-PC: jump target, pc+offset or pc+1, all wrapping
// modulo 2^ADDR_W.
module pc_next_calc
  import pc_sequencer_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              jump_en_i,
  input  logic [ADDR_W-1:0] jump_target_i,
  input  logic              br_taken_i,
  input  logic [ADDR_W-1:0] br_offset_i,
  output logic [ADDR_W-1:0] pc_nxt_o
);

  pc_sel_e sel;

  assign sel = pc_select(jump_en_i, br_taken_i);

  // Plain ADDR_W-bit adds: two's-complement offsets and wrap come for free.
  always_comb begin
    pc_nxt_o = pc_i + ADDR_W'(1);
    case (sel)
      SEL_JMP: pc_nxt_o = jump_target_i;
      SEL_BR:  pc_nxt_o = pc_i + br_offset_i;
      default: pc_nxt_o = pc_i + ADDR_W'(1);
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute controller owning the PC: req/ack instruction fetch with
// timeout, execute handoff, next-PC selection and halt.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int                ADDR_W     = DEF_ADDR_W,
  parameter int                INSTR_W    = DEF_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter int                TIMEOUT    = 15
) (
  input  logic          clk,
  input  logic          reset,
  pc_sequencer_if.master bus
);

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               vld_q, vld_d;
  logic               fault_q, fault_d;
  logic               pend_q, pend_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [7:0]         cnt_inc;
  logic [ADDR_W-1:0]  pc_nxt;

  pc_next_calc #(.ADDR_W(ADDR_W)) u_next (
    .pc_i          (pc_q),
    .jump_en_i     (bus.jump_en),
    .jump_target_i (bus.jump_target),
    .br_taken_i    (bus.br_taken),
    .br_offset_i   (bus.br_offset),
    .pc_nxt_o      (pc_nxt)
  );

  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    vld_d   = 1'b0;
    fault_d = fault_q;
    cnt_d   = cnt_q;
    // A halt request seen before retirement is held until the next exec_done.
    pend_d  = pend_q | bus.halt_req;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.imem_ack) begin
          instr_d = bus.imem_data;
          vld_d   = 1'b1;
          state_d = ST_EXEC;
        end else if (cnt_inc == TO_LIM) begin
          fault_d = 1'b1;
          pend_d  = 1'b0;
          state_d = ST_HALT;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_EXEC: begin
        if (bus.exec_done) begin
          pc_d = pc_nxt;
          if (bus.halt_req || pend_q) begin
            pend_d  = 1'b0;
            state_d = ST_HALT;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_HALT: begin
        pend_d = 1'b0;
      end
      default: begin
        pend_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_ADDR;
      instr_q <= '0;
      vld_q   <= 1'b0;
      fault_q <= 1'b0;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      vld_q   <= vld_d;
      fault_q <= fault_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.imem_req    = (state_q == ST_FETCH) || (state_q == ST_WAIT);
  assign bus.imem_addr   = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = vld_q;
  assign bus.pc          = pc_q;
  assign bus.busy        = (state_q == ST_FETCH) || (state_q == ST_WAIT) || (state_q == ST_EXEC);
  assign bus.fault       = fault_q;
  assign bus.halted      = (state_q == ST_HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized bench for pc_sequencer against a transaction-level PC model.
module tb_pc_sequencer;

  localparam int AW  = 8;
  localparam int MOD = 1 << AW;
  localparam int TO  = 15;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_sequencer_if #(.ADDR_W(8), .INSTR_W(32)) bus ();

  pc_sequencer #(.ADDR_W(8), .INSTR_W(32), .RESET_ADDR(8'h00), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0, fails = 0;
  int cyc = 0, valid_cyc = 0, t_start = 0;
  int mpc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic int model_next(input int p, input bit j, input int t, input bit b, input int o);
    if (j) return t;
    if (b) return (p + o) % MOD;
    return (p + 1) % MOD;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    mpc = 0;
    chk("rst_pc", 32'(bus.pc), 32'h0);
    chk("rst_req", 32'(bus.imem_req), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_halted", 32'(bus.halted), 32'h0);
    chk("rst_fault", 32'(bus.fault), 32'h0);
    chk("rst_valid", 32'(bus.instr_valid), 32'h0);
    chk("rst_instr", bus.instr, 32'h0);
  endtask

  task automatic begin_run();
    t_start = cyc;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  // One instruction from its FETCH cycle through retirement.
  task automatic fetch_exec(input int dly, input int edly, input logic [31:0] data,
                            input bit jmp, input int tgt, input bit br, input int off,
                            input bit hold_halt, input int hpulse, input bit noise);
    bit exp_halt;
    exp_halt = hold_halt || (hpulse >= 0 && hpulse < dly);
    chk("fetch_req", 32'(bus.imem_req), 32'h1);
    chk("fetch_addr", 32'(bus.imem_addr), 32'(mpc));
    step();
    for (int i = 0; i < dly; i++) begin
      chk("wait_req", 32'(bus.imem_req), 32'h1);
      chk("wait_addr", 32'(bus.imem_addr), 32'(mpc));
      if (i == hpulse) bus.halt_req = 1'b1;
      if (noise) begin
        bus.exec_done   = 1'($urandom_range(0, 1));
        bus.jump_en     = 1'b1;
        bus.jump_target = 8'($urandom);
      end
      step();
      bus.halt_req  = 1'b0;
      bus.exec_done = 1'b0;
      bus.jump_en   = 1'b0;
      chk("wait_pc", 32'(bus.pc), 32'(mpc));
    end
    bus.imem_ack  = 1'b1;
    bus.imem_data = data;
    step();
    bus.imem_ack  = 1'b0;
    bus.imem_data = $urandom;
    valid_cyc = cyc;
    chk("exec_valid", 32'(bus.instr_valid), 32'h1);
    chk("exec_instr", bus.instr, data);
    chk("exec_req", 32'(bus.imem_req), 32'h0);
    chk("exec_busy", 32'(bus.busy), 32'h1);
    for (int j = 0; j < edly; j++) begin
      step();
      chk("exec_pulse", 32'(bus.instr_valid), 32'h0);
      chk("exec_hold", bus.instr, data);
      chk("exec_pc", 32'(bus.pc), 32'(mpc));
    end
    bus.exec_done   = 1'b1;
    bus.jump_en     = jmp;
    bus.jump_target = 8'(tgt);
    bus.br_taken    = br;
    bus.br_offset   = 8'(off);
    bus.halt_req    = hold_halt;
    step();
    bus.exec_done = 1'b0;
    bus.jump_en   = 1'b0;
    bus.br_taken  = 1'b0;
    bus.halt_req  = 1'b0;
    mpc = model_next(mpc, jmp, tgt, br, off);
    chk("retire_pc", 32'(bus.pc), 32'(mpc));
    chk("retire_halted", 32'(bus.halted), 32'(exp_halt));
    chk("retire_req", 32'(bus.imem_req), 32'(!exp_halt));
  endtask

  task automatic check_frozen(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      chk({tag, "_halted"}, 32'(bus.halted), 32'h1);
      chk({tag, "_req"}, 32'(bus.imem_req), 32'h0);
      chk({tag, "_busy"}, 32'(bus.busy), 32'h0);
      chk({tag, "_pc"}, 32'(bus.pc), 32'(mpc));
    end
  endtask

  initial begin
    int n;
    logic [7:0] wrap_addr [3];
    bus.start = 0; bus.halt_req = 0; bus.imem_ack = 0; bus.imem_data = 0;
    bus.exec_done = 0; bus.jump_en = 0; bus.jump_target = 0;
    bus.br_taken = 0; bus.br_offset = 0;
    reset = 1'b0;

    // first instruction, ack after two WAIT cycles
    do_reset();
    step();
    chk("idle_stays", 32'(bus.busy), 32'h0);
    begin_run();
    fetch_exec(2, 1, 32'hDEADBEEF, 0, 0, 0, 0, 0, -1, 0);
    chk("t1_pc", 32'(bus.pc), 32'h01);
    chk("t1_next_addr", 32'(bus.imem_addr), 32'h01);

    // minimum start-to-valid latency
    do_reset();
    begin_run();
    fetch_exec(0, 0, 32'h12345678, 1, 8'hFE, 0, 0, 0, -1, 0);
    chk("latency", 32'(valid_cyc - t_start), 32'd3);

    // linear run across the wrap
    wrap_addr[0] = 8'hFE; wrap_addr[1] = 8'hFF; wrap_addr[2] = 8'h00;
    for (int k = 0; k < 3; k++) begin
      chk("wrap_addr", 32'(bus.imem_addr), 32'(wrap_addr[k]));
      fetch_exec(k, 0, $urandom, 0, 0, 0, 0, 0, -1, 0);
    end
    chk("wrap_pc", 32'(bus.pc), 32'h01);

    // branch back, then jump beats branch
    fetch_exec(1, 0, $urandom, 1, 8'h10, 0, 0, 0, -1, 0);
    fetch_exec(0, 1, $urandom, 0, 0, 1, 8'hF8, 0, -1, 0);
    chk("br_pc", 32'(bus.pc), 32'h08);
    fetch_exec(0, 0, $urandom, 1, 8'h40, 1, 8'h04, 0, -1, 0);
    chk("jmp_pc", 32'(bus.pc), 32'h40);
    fetch_exec(1, 0, $urandom, 0, 0, 1, 8'h02, 1, -1, 0);
    check_frozen(3, "halt_hold");

    // ack on the last allowed WAIT cycle wins over the timeout
    do_reset();
    begin_run();
    fetch_exec(TO - 1, 0, 32'hA5A5A5A5, 0, 0, 0, 0, 0, -1, 0);
    chk("late_ack_fault", 32'(bus.fault), 32'h0);

    // timeout with ack withheld
    do_reset();
    begin_run();
    step();
    n = 0;
    while (bus.imem_req && n < 40) begin
      n++;
      step();
    end
    chk("to_cycles", 32'(n), 32'(TO));
    chk("to_fault", 32'(bus.fault), 32'h1);
    chk("to_halted", 32'(bus.halted), 32'h1);
    bus.imem_ack = 1'b1;
    bus.imem_data = 32'hCAFEF00D;
    check_frozen(3, "to_frozen");
    bus.imem_ack = 1'b0;
    chk("to_instr", bus.instr, 32'h0);
    chk("to_fault_sticky", 32'(bus.fault), 32'h1);
    do_reset();

    // halt_req pulsed during WAIT takes effect at retirement
    begin_run();
    fetch_exec(3, 1, $urandom, 0, 0, 0, 0, 0, 1, 0);
    chk("hpend_pc", 32'(bus.pc), 32'h01);
    check_frozen(4, "hpend");

    // reset in the middle of a fetch
    do_reset();
    begin_run();
    fetch_exec(0, 0, $urandom, 1, 8'h33, 0, 0, 0, -1, 0);
    step();
    chk("midrst_req_pre", 32'(bus.imem_req), 32'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    mpc = 0;
    chk("midrst_req", 32'(bus.imem_req), 32'h0);
    chk("midrst_pc", 32'(bus.pc), 32'h0);
    chk("midrst_busy", 32'(bus.busy), 32'h0);
    bus.imem_ack = 1'b1;
    bus.imem_data = 32'h0BADF00D;
    step();
    bus.imem_ack = 1'b0;
    chk("midrst_valid", 32'(bus.instr_valid), 32'h0);
    chk("midrst_instr", bus.instr, 32'h0);
    chk("midrst_idle", 32'(bus.busy), 32'h0);

    // randomized program
    do_reset();
    begin_run();
    for (int k = 0; k < 25; k++) begin
      fetch_exec($urandom_range(0, TO - 1), $urandom_range(0, 2), $urandom,
                 ($urandom_range(0, 3) == 0), $urandom_range(0, MOD - 1),
                 ($urandom_range(0, 2) == 0), $urandom_range(0, MOD - 1),
                 (k == 24), -1, 1);
    end
    check_frozen(2, "rand_end");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
